// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared widths and dimensions for the matrix-multiply
//               accelerator (operand memories and systolic array).
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

   // Signed operand width for the A and B matrices
   localparam int BITS_AB = 8;

   // Signed accumulator width for C
   localparam int BITS_C  = 16;

   // Array dimension (rows = columns)
   localparam int DIM     = 8;

   // Number of enabled cycles after which a full product is resident
   function automatic int full_product_cycles(input int dim);
      return 3 * dim - 2;
   endfunction

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/tpumac.sv
`default_nettype none
// ============================================================================
// Module      : tpumac
// Description : One systolic processing element. Forwards its A operand to
//               the right and its B operand downward through one register
//               each, and accumulates their product into a wrapping signed
//               accumulator. A row load (WrEn) overrides the accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
module tpumac #(
   parameter int BITS_AB = tpu_pkg::BITS_AB,
   parameter int BITS_C  = tpu_pkg::BITS_C
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               WrEn,
   input  logic [BITS_AB-1:0] Ain,
   input  logic [BITS_AB-1:0] Bin,
   input  logic [BITS_C-1:0]  Cin,
   output logic [BITS_AB-1:0] Aout,
   output logic [BITS_AB-1:0] Bout,
   output logic [BITS_C-1:0]  Cout
);
   import tpu_pkg::*;

   // Full-precision product width
   localparam int PW = 2 * BITS_AB;

   logic [BITS_AB-1:0] a_q, a_d;
   logic [BITS_AB-1:0] b_q, b_d;
   logic [BITS_C-1:0]  c_q, c_d;

   // Operands sign-extended to the product width so that a plain multiply
   // yields the exact two's-complement product in its low PW bits.
   logic [PW-1:0]      w_a_ext;
   logic [PW-1:0]      w_b_ext;
   logic [PW-1:0]      w_prod;
   logic [BITS_C-1:0]  w_prod_c;

   assign w_a_ext = {{BITS_AB{Ain[BITS_AB-1]}}, Ain};
   assign w_b_ext = {{BITS_AB{Bin[BITS_AB-1]}}, Bin};
   assign w_prod  = w_a_ext * w_b_ext;

   // Fit the product to the accumulator: sign-extend when wider, keep the
   // low bits when narrower (the sum wraps anyway).
   generate
      if (BITS_C > PW) begin : g_prod_ext
         assign w_prod_c = {{(BITS_C-PW){w_prod[PW-1]}}, w_prod};
      end else if (BITS_C == PW) begin : g_prod_same
         assign w_prod_c = w_prod;
      end else begin : g_prod_trunc
         assign w_prod_c = w_prod[BITS_C-1:0];
      end
   endgenerate

   // Next state: operands shift on en; a row load wins over the MAC result
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      if (en) begin
         a_d = Ain;
         b_d = Bin;
      end
      if (WrEn) begin
         c_d = Cin;
      end else if (en) begin
         c_d = c_q + w_prod_c;
      end
   end

   // PE registers with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
      end
   end

   assign Aout = a_q;
   assign Bout = b_q;
   assign Cout = c_q;

endmodule : tpumac
`default_nettype wire

// File: rtl/systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array
// Description : DIM x DIM grid of tpumac elements. A operands enter on the
//               left edge and travel right, B operands enter on the top edge
//               and travel down, both pre-skewed by the operand memories.
//               Accumulators are loaded and read one row at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array #(
   parameter int BITS_AB = tpu_pkg::BITS_AB,
   parameter int BITS_C  = tpu_pkg::BITS_C,
   parameter int DIM     = tpu_pkg::DIM
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    WrEn,
   input  logic [DIM*BITS_AB-1:0]  A,
   input  logic [DIM*BITS_AB-1:0]  B,
   input  logic [DIM*BITS_C-1:0]   Cin,
   input  logic [$clog2(DIM)-1:0]  Crow,
   output logic [DIM*BITS_C-1:0]   Cout
);
   import tpu_pkg::*;

   localparam int SEL_W = $clog2(DIM);

   // Registered operand outputs and accumulators of every PE
   logic [BITS_AB-1:0] w_a [DIM][DIM];
   logic [BITS_AB-1:0] w_b [DIM][DIM];
   logic [BITS_C-1:0]  w_c [DIM][DIM];

   // Per-row load strobe decoded from Crow
   logic [DIM-1:0]     w_row_wr;

   // Operands leaving the right and bottom edges go nowhere
   logic [DIM*BITS_AB-1:0] w_unused_a_edge;
   logic [DIM*BITS_AB-1:0] w_unused_b_edge;

   generate
      for (genvar i = 0; i < DIM; i++) begin : g_row
         assign w_row_wr[i] = WrEn && (Crow == SEL_W'(i));
         assign w_unused_a_edge[i*BITS_AB +: BITS_AB] = w_a[i][DIM-1];
         assign w_unused_b_edge[i*BITS_AB +: BITS_AB] = w_b[DIM-1][i];

         for (genvar j = 0; j < DIM; j++) begin : g_col
            logic [BITS_AB-1:0] w_ain;
            logic [BITS_AB-1:0] w_bin;

            // Left column takes the external A lane, others the left neighbour
            if (j == 0) begin : g_a_edge
               assign w_ain = A[i*BITS_AB +: BITS_AB];
            end else begin : g_a_link
               assign w_ain = w_a[i][j-1];
            end

            // Top row takes the external B lane, others the upper neighbour
            if (i == 0) begin : g_b_edge
               assign w_bin = B[j*BITS_AB +: BITS_AB];
            end else begin : g_b_link
               assign w_bin = w_b[i-1][j];
            end

            tpumac #(
               .BITS_AB (BITS_AB),
               .BITS_C  (BITS_C)
            ) u_pe (
               .clk   (clk),
               .rst_n (rst_n),
               .en    (en),
               .WrEn  (w_row_wr[i]),
               .Ain   (w_ain),
               .Bin   (w_bin),
               .Cin   (Cin[j*BITS_C +: BITS_C]),
               .Aout  (w_a[i][j]),
               .Bout  (w_b[i][j]),
               .Cout  (w_c[i][j])
            );
         end
      end
   endgenerate

   // Row readback mux: purely from accumulator registers, never from A/B
   always_comb begin
      Cout = '0;
      for (int j = 0; j < DIM; j++) begin
         Cout[j*BITS_C +: BITS_C] = w_c[Crow][j];
      end
   end

endmodule : systolic_array
`default_nettype wire
